// File: rtl/vga_console_pkg.sv
// Shared types and constants for the VGA text console bus master.
package vga_console_pkg;

   // Master FSM states
   typedef enum logic [2:0] {
      StIdle,
      StWrChar,
      StWrCol,
      StClrChar,
      StClrCol
   } state_e;

   // Control characters recognised by the console
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Offsets of the two maps inside the VGA controller window
   localparam logic [31:0] CHAR_MAP_OFF = 32'h0000_0000;
   localparam logic [31:0] COL_MAP_OFF  = 32'h0000_1000;

   // Word-aligned byte address of a 32-bit word inside one of the maps
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [31:0] off,
                                             input logic [9:0]  word);
      return base + off + {20'd0, word, 2'b00};
   endfunction

   // True for bytes that are handled as commands rather than printed
   function automatic logic is_ctrl(input logic [7:0] c);
      return (c == ASCII_BS) || (c == ASCII_LF) || (c == ASCII_FF) || (c == ASCII_CR);
   endfunction

endpackage

// File: rtl/vga_console_master_cursor.sv
// Text cursor: row/column registers with advance, newline, CR, BS and home.
module vga_cursor #(
   parameter int unsigned COLS = 80,
   parameter int unsigned ROWS = 30
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        advance_i,
   input  logic        newline_i,
   input  logic        cr_i,
   input  logic        bs_i,
   input  logic        home_i,
   output logic [6:0]  col_o,
   output logic [4:0]  row_o,
   output logic [11:0] pos_o
);

   logic [6:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic [4:0] row_next;

   // Next-state cursor position; home wins over everything else
   always_comb begin
      col_d    = col_q;
      row_d    = row_q;
      row_next = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      if (home_i) begin
         col_d = 7'd0;
         row_d = 5'd0;
      end else if (advance_i) begin
         if (col_q == 7'(COLS - 1)) begin
            col_d = 7'd0;
            row_d = row_next;
         end else begin
            col_d = col_q + 7'd1;
         end
      end else if (newline_i) begin
         col_d = 7'd0;
         row_d = row_next;
      end else if (cr_i) begin
         col_d = 7'd0;
      end else if (bs_i) begin
         if (col_q != 7'd0) begin
            col_d = col_q - 7'd1;
         end
      end
   end

   // Cursor registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q <= 7'd0;
         row_q <= 5'd0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   // Linear character index of the cursor
   always_comb begin
      pos_o = 12'(row_q) * 12'(COLS) + 12'(col_q);
   end

   assign col_o = col_q;
   assign row_o = row_q;

endmodule

// File: rtl/vga_console_master.sv
// Byte-stream to VGA text map bus initiator with cursor and control chars.
module vga_console_master
   import vga_console_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0700_0000,
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 30
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        char_valid_i,
   input  logic [7:0]  char_i,
   input  logic [7:0]  color_i,
   output logic        char_ready_o,
   output logic        req_o,
   output logic        write_enable_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] addr_o,
   output logic [31:0] write_data_o,
   input  logic [31:0] read_data_i,
   output logic [6:0]  cursor_col_o,
   output logic [4:0]  cursor_row_o,
   output logic        busy_o
);

   localparam int unsigned NumWords = COLS * ROWS / 4;
   localparam logic [9:0]  LastWord = 10'(NumWords - 1);

   state_e      state_q;
   logic [7:0]  color_q;
   logic [9:0]  word_q;
   logic        req_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [11:0] pos;
   logic        accept;
   logic        last_word;
   logic        cmd_advance, cmd_newline, cmd_cr, cmd_bs, cmd_home;

   logic unused_read_data;
   assign unused_read_data = ^read_data_i;

   // Cursor commands decoded from the accepted byte and the FSM state
   always_comb begin
      accept      = char_valid_i && (state_q == StIdle);
      last_word   = (word_q == LastWord);
      cmd_newline = accept && (char_i == ASCII_LF);
      cmd_cr      = accept && (char_i == ASCII_CR);
      cmd_bs      = accept && (char_i == ASCII_BS);
      cmd_advance = (state_q == StWrCol);
      cmd_home    = (state_q == StClrCol) && last_word;
   end

   vga_cursor #(
      .COLS(COLS),
      .ROWS(ROWS)
   ) u_cursor (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .advance_i(cmd_advance),
      .newline_i(cmd_newline),
      .cr_i     (cmd_cr),
      .bs_i     (cmd_bs),
      .home_i   (cmd_home),
      .col_o    (cursor_col_o),
      .row_o    (cursor_row_o),
      .pos_o    (pos)
   );

   // FSM with registered bus outputs; each state's bus cycle is set up one edge early
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         color_q <= 8'd0;
         word_q  <= 10'd0;
         req_q   <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= BASE_ADDR;
         wdata_q <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (char_valid_i) begin
                  if (char_i == ASCII_FF) begin
                     word_q  <= 10'd0;
                     color_q <= color_i;
                     state_q <= StClrChar;
                     req_q   <= 1'b1;
                     be_q    <= 4'hF;
                     addr_q  <= word_addr(BASE_ADDR, CHAR_MAP_OFF, 10'd0);
                     wdata_q <= {4{ASCII_SPACE}};
                  end else if (!is_ctrl(char_i)) begin
                     color_q <= color_i;
                     state_q <= StWrChar;
                     req_q   <= 1'b1;
                     be_q    <= 4'b0001 << pos[1:0];
                     addr_q  <= word_addr(BASE_ADDR, CHAR_MAP_OFF, pos[11:2]);
                     wdata_q <= {4{char_i}};
                  end
               end
            end
            StWrChar: begin
               // Same byte lane, colour map, cursor not yet moved
               state_q <= StWrCol;
               addr_q  <= word_addr(BASE_ADDR, COL_MAP_OFF, pos[11:2]);
               wdata_q <= {4{color_q}};
            end
            StWrCol: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
               be_q    <= 4'd0;
               addr_q  <= BASE_ADDR;
               wdata_q <= 32'd0;
            end
            StClrChar: begin
               state_q <= StClrCol;
               addr_q  <= word_addr(BASE_ADDR, COL_MAP_OFF, word_q);
               wdata_q <= {4{color_q}};
            end
            StClrCol: begin
               if (last_word) begin
                  state_q <= StIdle;
                  req_q   <= 1'b0;
                  be_q    <= 4'd0;
                  addr_q  <= BASE_ADDR;
                  wdata_q <= 32'd0;
               end else begin
                  word_q  <= word_q + 10'd1;
                  state_q <= StClrChar;
                  addr_q  <= word_addr(BASE_ADDR, CHAR_MAP_OFF, word_q + 10'd1);
                  wdata_q <= {4{ASCII_SPACE}};
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
               be_q    <= 4'd0;
               addr_q  <= BASE_ADDR;
               wdata_q <= 32'd0;
            end
         endcase
      end
   end

   // Output mapping from registered state
   always_comb begin
      char_ready_o   = (state_q == StIdle);
      busy_o         = (state_q != StIdle);
      req_o          = req_q;
      write_enable_o = req_q;
      mem_be_o       = be_q;
      addr_o         = addr_q;
      write_data_o   = wdata_q;
   end

endmodule

// File: tb/tb_vga_console_master.sv
// Directed self-checking bench for vga_console_master at default parameters.
module tb_vga_console_master;

   localparam logic [31:0] BASE = 32'h0700_0000;

   logic        clk;
   logic        rst;
   logic        char_valid;
   logic [7:0]  char_in;
   logic [7:0]  color_in;
   logic        char_ready;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [6:0]  col;
   logic [4:0]  row;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   vga_console_master #(
      .BASE_ADDR(BASE),
      .COLS     (80),
      .ROWS     (30)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .char_valid_i  (char_valid),
      .char_i        (char_in),
      .color_i       (color_in),
      .char_ready_o  (char_ready),
      .req_o         (req),
      .write_enable_o(we),
      .mem_be_o      (be),
      .addr_o        (addr),
      .write_data_o  (wdata),
      .read_data_i   (32'hDEAD_BEEF),
      .cursor_col_o  (col),
      .cursor_row_o  (row),
      .busy_o        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Offer one byte for exactly one edge; returns 1 time unit after that edge
   task automatic send_byte(input logic [7:0] c, input logic [7:0] clr);
      @(negedge clk);
      char_valid = 1'b1;
      char_in    = c;
      color_in   = clr;
      @(posedge clk);
      #1;
      char_valid = 1'b0;
   endtask

   // Printable byte: wait until ready is back in cycle N+3
   task automatic print_char(input logic [7:0] c, input logic [7:0] clr);
      send_byte(c, clr);
      repeat (3) @(negedge clk);
   endtask

   // Control byte: no bus cycle, ready stays high, cursor updated at the accept edge
   task automatic send_ctrl(input string tag, input logic [7:0] c,
                            input logic [4:0] exp_row, input logic [6:0] exp_col);
      send_byte(c, 8'h00);
      check_val({tag, "_req"}, 32'(req), 32'd0);
      check_val({tag, "_ready"}, 32'(char_ready), 32'd1);
      check_val({tag, "_row"}, 32'(row), 32'(exp_row));
      check_val({tag, "_col"}, 32'(col), 32'(exp_col));
   endtask

   initial begin
      int          n_req;
      int          bad;
      int          cyc;
      logic [31:0] last_addr;
      logic [31:0] exp_addr;
      logic [31:0] exp_data;
      logic        found;

      rst        = 1'b1;
      char_valid = 1'b0;
      char_in    = 8'h00;
      color_in   = 8'h00;
      repeat (3) @(negedge clk);

      // Reset values while reset is held
      check_val("rst_req", 32'(req), 32'd0);
      check_val("rst_we", 32'(we), 32'd0);
      check_val("rst_be", 32'(be), 32'd0);
      check_val("rst_wdata", wdata, 32'd0);
      check_val("rst_addr", addr, BASE);
      check_val("rst_ready", 32'(char_ready), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_cursor", {20'd0, row, col}, 32'd0);
      rst = 1'b0;

      // 'A' with colour 0x0F at (0,0)
      send_byte(8'h41, 8'h0F);
      @(negedge clk);
      check_val("a_req", 32'(req), 32'd1);
      check_val("a_we", 32'(we), 32'd1);
      check_val("a_busy", 32'(busy), 32'd1);
      check_val("a_ready_busy", 32'(char_ready), 32'd0);
      check_val("a_chr_addr", addr, BASE);
      check_val("a_chr_be", 32'(be), 32'h1);
      check_val("a_chr_data", wdata, 32'h4141_4141);
      @(negedge clk);
      check_val("a_col_req", 32'(req), 32'd1);
      check_val("a_col_addr", addr, BASE + 32'h1000);
      check_val("a_col_be", 32'(be), 32'h1);
      check_val("a_col_data", wdata, 32'h0F0F_0F0F);
      @(negedge clk);
      check_val("a_done_req", 32'(req), 32'd0);
      check_val("a_done_addr", addr, BASE);
      check_val("a_done_ready", 32'(char_ready), 32'd1);
      check_val("a_done_row", 32'(row), 32'd0);
      check_val("a_done_col", 32'(col), 32'd1);

      // Move to (1,3) and print 'Z': pos 83 -> word 0x50, lane 3
      send_ctrl("lf1", 8'h0A, 5'd1, 7'd0);
      for (int i = 0; i < 3; i++) print_char(8'h2E, 8'h07);
      check_val("pos13", {20'd0, row, col}, {20'd0, 5'd1, 7'd3});
      send_byte(8'h5A, 8'h07);
      @(negedge clk);
      check_val("z_chr_addr", addr, BASE + 32'h50);
      check_val("z_chr_be", 32'(be), 32'h8);
      check_val("z_chr_data", wdata, 32'h5A5A_5A5A);
      @(negedge clk);
      check_val("z_col_addr", addr, BASE + 32'h1050);
      check_val("z_col_data", wdata, 32'h0707_0707);
      @(negedge clk);
      check_val("z_cursor", {20'd0, row, col}, {20'd0, 5'd1, 7'd4});

      // Reach (29,79) and print the last cell: pos 2399 -> word 0x95C, lane 3
      for (int r = 2; r < 30; r++) send_ctrl("lf_walk", 8'h0A, 5'(r), 7'd0);
      for (int i = 0; i < 79; i++) print_char(8'h23, 8'h07);
      check_val("pos29_79", {20'd0, row, col}, {20'd0, 5'd29, 7'd79});
      send_byte(8'h21, 8'h07);
      @(negedge clk);
      check_val("last_chr_addr", addr, BASE + 32'h95C);
      check_val("last_chr_be", 32'(be), 32'h8);
      @(negedge clk);
      check_val("last_col_addr", addr, BASE + 32'h195C);
      @(negedge clk);
      check_val("wrap_cursor", {20'd0, row, col}, 32'd0);

      // LF wrap at the last row, BS at column 0, BS and CR mid-line
      for (int r = 1; r < 30; r++) send_ctrl("lf_down", 8'h0A, 5'(r), 7'd0);
      send_ctrl("lf_wrap", 8'h0A, 5'd0, 7'd0);
      send_ctrl("bs_col0", 8'h08, 5'd0, 7'd0);
      print_char(8'h31, 8'h07);
      print_char(8'h32, 8'h07);
      send_ctrl("bs_mid", 8'h08, 5'd0, 7'd1);
      send_ctrl("cr_mid", 8'h0D, 5'd0, 7'd0);
      print_char(8'h33, 8'h07);

      // Full clear with colour 0x1E from cursor (0,1)
      send_byte(8'h0C, 8'h1E);
      n_req     = 0;
      bad       = 0;
      cyc       = 0;
      last_addr = 32'd0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!busy) break;
         if (req) begin
            exp_addr = BASE + ((n_req % 2 == 1) ? 32'h1000 : 32'h0) + 32'((n_req / 2) * 4);
            exp_data = (n_req % 2 == 1) ? 32'h1E1E_1E1E : 32'h2020_2020;
            if (n_req == 0) begin
               check_val("ff_first_addr", addr, BASE);
               check_val("ff_first_data", wdata, 32'h2020_2020);
               check_val("ff_first_be", 32'(be), 32'hF);
            end else if (n_req == 1) begin
               check_val("ff_second_addr", addr, BASE + 32'h1000);
               check_val("ff_second_data", wdata, 32'h1E1E_1E1E);
            end
            if (addr !== exp_addr || wdata !== exp_data || be !== 4'hF || we !== 1'b1) bad++;
            last_addr = addr;
            n_req++;
         end
      end
      check_val("ff_timeout", 32'(cyc < 3000), 32'd1);
      check_val("ff_req_count", 32'(n_req), 32'd1200);
      check_val("ff_seq_errors", 32'(bad), 32'd0);
      check_val("ff_last_addr", last_addr, BASE + 32'h195C);
      check_val("ff_cursor", {20'd0, row, col}, 32'd0);
      check_val("ff_busy", 32'(busy), 32'd0);
      check_val("ff_req_after", 32'(req), 32'd0);

      // Reset asserted during the clear at word 100
      print_char(8'h34, 8'h07);
      send_byte(8'h0C, 8'h55);
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (req && addr == BASE + 32'h190) begin
            found = 1'b1;
            break;
         end
      end
      check_val("mid_clear_found", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_req", 32'(req), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_ready", 32'(char_ready), 32'd1);
      check_val("mid_rst_addr", addr, BASE);
      check_val("mid_rst_cursor", {20'd0, row, col}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_idle", 32'(busy), 32'd0);

      // First byte after the interrupted clear prints normally
      send_byte(8'h42, 8'h07);
      @(negedge clk);
      check_val("b_chr_addr", addr, BASE);
      check_val("b_chr_be", 32'(be), 32'h1);
      check_val("b_chr_data", wdata, 32'h4242_4242);
      @(negedge clk);
      check_val("b_col_addr", addr, BASE + 32'h1000);
      check_val("b_col_data", wdata, 32'h0707_0707);
      @(negedge clk);
      check_val("b_cursor", {20'd0, row, col}, {20'd0, 5'd0, 7'd1});
      check_val("b_ready", 32'(char_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
